// File: rtl/state_sequencer.sv
// Instruction-phase sequencer: walks HALT/FETCH/DECODE/EXEC1/EXEC2, holds on bus or
// multiply/divide stalls, aborts to HALT on a bus stall timeout, and counts retired instructions.
module state_sequencer #(
  parameter int unsigned WAIT_TIMEOUT = 255,
  parameter logic [31:0] HALT_ADDR    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        waitrequest,
  input  logic        memread,
  input  logic        memwrite,
  input  logic        muldiv_busy,
  input  logic [31:0] pc_next,
  output logic [3:0]  state,
  output logic        active,
  output logic        stall,
  output logic        bus_error,
  output logic [31:0] instr_count
);

  // state  | meaning
  // HALT   | idle; leaves once after reset via the start flag, otherwise parked
  // FETCH  | instruction fetch, held by waitrequest
  // DECODE | single-cycle decode
  // EXEC1  | execute, held by a stalled memory access or a busy mul/div unit
  // EXEC2  | writeback, held by a stalled memory access; retires the instruction
  typedef enum logic [3:0] {
    S_HALT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC1  = 4'd3,
    S_EXEC2  = 4'd4
  } state_e;

  localparam logic [9:0] WAIT_LAST = 10'(WAIT_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        start_q, start_d;
  logic        bus_error_q, bus_error_d;
  logic [9:0]  wait_cnt_q, wait_cnt_d;
  logic [31:0] instr_count_q, instr_count_d;

  logic mem_req;
  logic wr_stall;
  logic mul_stall;
  logic timeout;
  logic retire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_HALT;
      start_q       <= 1'b1;
      bus_error_q   <= 1'b0;
      wait_cnt_q    <= '0;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      start_q       <= start_d;
      bus_error_q   <= bus_error_d;
      wait_cnt_q    <= wait_cnt_d;
      instr_count_q <= instr_count_d;
    end
  end

  // Only waitrequest-caused holds feed the timeout counter; mul/div holds never abort.
  always_comb begin
    mem_req   = memread | memwrite;
    wr_stall  = 1'b0;
    mul_stall = 1'b0;
    case (state_q)
      S_FETCH: wr_stall = waitrequest;
      S_EXEC1: begin
        wr_stall  = mem_req & waitrequest;
        mul_stall = muldiv_busy;
      end
      S_EXEC2: wr_stall = mem_req & waitrequest;
      default: ;
    endcase
    stall      = wr_stall | mul_stall;
    timeout    = wr_stall && (wait_cnt_q == WAIT_LAST);
    wait_cnt_d = wr_stall ? wait_cnt_q + 10'd1 : 10'd0;
  end

  always_comb begin
    state_d     = state_q;
    start_d     = start_q;
    bus_error_d = bus_error_q;
    retire      = 1'b0;
    case (state_q)
      S_HALT: begin
        if (start_q) begin
          state_d = S_FETCH;
          start_d = 1'b0;
        end
      end
      S_FETCH:  if (!stall) state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC1;
      S_EXEC1:  if (!stall) state_d = S_EXEC2;
      S_EXEC2: begin
        if (!stall) begin
          retire  = 1'b1;
          state_d = (pc_next == HALT_ADDR) ? S_HALT : S_FETCH;
        end
      end
      default: begin
        state_d     = S_HALT;
        bus_error_d = 1'b1;
      end
    endcase
    // A timed-out access aborts the instruction without retiring it.
    if (timeout) begin
      state_d     = S_HALT;
      bus_error_d = 1'b1;
      retire      = 1'b0;
    end
    instr_count_d = instr_count_q + 32'(retire);
  end

  assign state       = state_q;
  assign active      = (state_q != S_HALT);
  assign bus_error   = bus_error_q;
  assign instr_count = instr_count_q;

endmodule

// File: tb/tb_state_sequencer.sv
// Directed bench for state_sequencer with a short bus timeout of 4 stalled cycles.
module tb_state_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        waitrequest;
  logic        memread;
  logic        memwrite;
  logic        muldiv_busy;
  logic [31:0] pc_next;
  logic [3:0]  state;
  logic        active;
  logic        stall;
  logic        bus_error;
  logic [31:0] instr_count;

  int n_chk  = 0;
  int n_fail = 0;

  state_sequencer #(.WAIT_TIMEOUT(4), .HALT_ADDR(32'h0000_0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .waitrequest (waitrequest),
    .memread     (memread),
    .memwrite    (memwrite),
    .muldiv_busy (muldiv_busy),
    .pc_next     (pc_next),
    .state       (state),
    .active      (active),
    .stall       (stall),
    .bus_error   (bus_error),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Unstalled instruction from reset release: 1,2,3,4 then back to FETCH.
  task automatic plain_run(input string tag, input logic [31:0] exp_cnt);
    logic [3:0] seq [4] = '{4'd1, 4'd2, 4'd3, 4'd4};
    for (int i = 0; i < 4; i++) begin
      tick();
      chk({tag, "_state"}, 32'(state), 32'(seq[i]));
      chk({tag, "_active"}, 32'(active), 32'd1);
      chk({tag, "_stall"}, 32'(stall), 32'd0);
    end
    tick();
    chk({tag, "_refetch"}, 32'(state), 32'd1);
    chk({tag, "_count"}, instr_count, exp_cnt);
  endtask

  initial begin
    rst_n       = 1'b0;
    waitrequest = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    muldiv_busy = 1'b0;
    pc_next     = 32'h0000_0100;
    #3;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_active", 32'(active), 32'd0);
    chk("rst_err", 32'(bus_error), 32'd0);
    chk("rst_cnt", instr_count, 32'd0);

    release_reset();
    chk("pre_edge_state", 32'(state), 32'd0);
    plain_run("seq1", 32'd1);

    // FETCH held by 3 waitrequest cycles.
    waitrequest = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #0;
      chk("fetch_hold_state", 32'(state), 32'd1);
      chk("fetch_hold_stall", 32'(stall), 32'd1);
      tick();
    end
    waitrequest = 1'b0;
    #0;
    chk("fetch_rel_state", 32'(state), 32'd1);
    chk("fetch_rel_stall", 32'(stall), 32'd0);
    tick();
    chk("fetch_to_decode", 32'(state), 32'd2);
    tick();
    chk("exec1_entry", 32'(state), 32'd3);

    // EXEC1 load held 2 cycles by waitrequest.
    memread = 1'b1;
    waitrequest = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #0;
      chk("lw_hold_stall", 32'(stall), 32'd1);
      tick();
      chk("lw_hold_state", 32'(state), 32'd3);
    end
    waitrequest = 1'b0;
    #0;
    chk("lw_rel_stall", 32'(stall), 32'd0);
    tick();
    chk("lw_exec2", 32'(state), 32'd4);
    memread = 1'b0;
    tick();
    chk("lw_retire_state", 32'(state), 32'd1);
    chk("lw_retire_cnt", instr_count, 32'd2);

    // mul/div holds EXEC1 5 cycles; waitrequest without a request must not count toward timeout.
    tick();
    tick();
    chk("md_exec1", 32'(state), 32'd3);
    muldiv_busy = 1'b1;
    waitrequest = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #0;
      chk("md_hold_stall", 32'(stall), 32'd1);
      tick();
      chk("md_hold_state", 32'(state), 32'd3);
    end
    muldiv_busy = 1'b0;
    #0;
    chk("md_rel_stall", 32'(stall), 32'd0);
    tick();
    chk("md_exec2", 32'(state), 32'd4);
    chk("md_no_err", 32'(bus_error), 32'd0);

    // EXEC2 store held 3 cycles, then halts on pc_next == HALT_ADDR.
    memwrite = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #0;
      chk("sw_hold_stall", 32'(stall), 32'd1);
      tick();
      chk("sw_hold_state", 32'(state), 32'd4);
    end
    waitrequest = 1'b0;
    pc_next = 32'h0000_0000;
    tick();
    memwrite = 1'b0;
    chk("halt_state", 32'(state), 32'd0);
    chk("halt_active", 32'(active), 32'd0);
    chk("halt_cnt", instr_count, 32'd3);
    chk("halt_no_err", 32'(bus_error), 32'd0);
    for (int i = 0; i < 100; i++) begin
      tick();
      if (i % 25 == 24) begin
        chk("halt_park_state", 32'(state), 32'd0);
        chk("halt_park_cnt", instr_count, 32'd3);
      end
    end

    // Timeout: 4 stalled FETCH cycles abort to HALT with a sticky bus_error.
    #2 rst_n = 1'b0;
    #1;
    pc_next = 32'h0000_0100;
    release_reset();
    tick();
    chk("to_fetch", 32'(state), 32'd1);
    waitrequest = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("to_hold_state", 32'(state), 32'd1);
      chk("to_hold_err", 32'(bus_error), 32'd0);
    end
    tick();
    chk("to_halt_state", 32'(state), 32'd0);
    chk("to_halt_err", 32'(bus_error), 32'd1);
    waitrequest = 1'b0;
    repeat (10) tick();
    chk("to_sticky_err", 32'(bus_error), 32'd1);
    chk("to_sticky_state", 32'(state), 32'd0);
    chk("to_sticky_cnt", instr_count, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("to_clr_err", 32'(bus_error), 32'd0);

    // Reset mid EXEC1 stall after one retired instruction.
    release_reset();
    plain_run("seq2", 32'd1);
    tick();
    tick();
    chk("ar_exec1", 32'(state), 32'd3);
    memread = 1'b1;
    waitrequest = 1'b1;
    tick();
    chk("ar_stalled", 32'(state), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_state", 32'(state), 32'd0);
    chk("ar_cnt", instr_count, 32'd0);
    memread = 1'b0;
    waitrequest = 1'b0;
    release_reset();
    plain_run("seq3", 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
